// File: rtl/multiplier_factor_search_pkg.sv
// multiplier_factor_pkg: shared state encoding, enumeration bounds and sweep-size helper.
package multiplier_factor_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, CMP, FIN} state_e;
  localparam int A_MIN = 2;
  localparam int B_MIN = 2;
  function automatic int sweep_count(input int a_w, input int b_w);
    return ((1 << a_w) - A_MIN) * ((1 << b_w) - B_MIN);
  endfunction
endpackage

// File: rtl/multiplier_factor_search_if.sv
// multiplier_factor_search_if: request/result bundle between a requester and the factor search.
interface multiplier_factor_search_if #(
  parameter int A_W = 4,
  parameter int B_W = 3
);
  localparam int P_W = A_W + B_W;
  logic           start;
  logic [P_W-1:0] target;
  logic           busy;
  logic           done;
  logic           found;
  logic [A_W-1:0] a_out;
  logic [B_W-1:0] b_out;
  modport master (output start, target, input busy, done, found, a_out, b_out);
  modport slave (input start, target, output busy, done, found, a_out, b_out);
endinterface

// File: rtl/multiplier_factor_search_mul.sv
// shift_add_mul: B_W-cycle shift-add multiplier; valid marks the final accumulate cycle.
module shift_add_mul #(
  parameter int A_W = 4,
  parameter int B_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] acc,
  output logic               valid
);
  localparam int P_W = A_W + B_W;
  localparam int C_W = $clog2(B_W + 1);
  logic [P_W-1:0] acc_q;
  logic [P_W-1:0] mcand_q;
  logic [B_W-1:0] mplier_q;
  logic [C_W-1:0] cnt_q;
  logic           run_q;
  assign valid = run_q && cnt_q == C_W'(B_W - 1);
  assign acc = acc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      acc_q <= '0;
      mcand_q <= P_W'(a);
      mplier_q <= b;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q <= cnt_q + C_W'(1);
      run_q <= !valid;
    end
  end
endmodule

// File: rtl/multiplier_factor_search.sv
// multiplier_factor_search: a-major/b-minor factor sweep for a target N.
// FACTOR_SEARCH_PRUNE_EN skips the rest of a row once the product exceeds N.
import multiplier_factor_pkg::*;
module multiplier_factor_search #(
  parameter int A_W = 4,
  parameter int B_W = 3
) (
  input logic                        clk,
  input logic                        rst,
  multiplier_factor_search_if.slave  bus
);
  localparam int P_W = A_W + B_W;
  state_e         state_q;
  logic [P_W-1:0] target_q;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic           busy_q;
  logic           done_q;
  logic           found_q;
  logic [A_W-1:0] a_out_q;
  logic [B_W-1:0] b_out_q;
  logic [P_W-1:0] acc;
  logic           valid;
  logic           load;
  logic           hit;
  logic           over;
  logic           b_more;
  logic           a_more;
  assign load = state_q == LOAD;
  // acc is stable after MUL, so hit is still meaningful in FIN
  assign hit = acc == target_q;
`ifdef FACTOR_SEARCH_PRUNE_EN
  assign over = acc > target_q;
`else
  assign over = 1'b0;
`endif
  assign b_more = !over && !(&b_q);
  assign a_more = !(&a_q);
  shift_add_mul #(.A_W(A_W), .B_W(B_W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .a     (a_q),
    .b     (b_q),
    .acc   (acc),
    .valid (valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      target_q <= '0;
      a_q <= '0;
      b_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      found_q <= 1'b0;
      a_out_q <= '0;
      b_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            target_q <= bus.target;
            a_q <= A_W'(A_MIN);
            b_q <= B_W'(B_MIN);
            found_q <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
            busy_q <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: state_q <= MUL;
        MUL: if (valid) state_q <= CMP;
        CMP: begin
          if (hit) state_q <= FIN;
          else if (b_more) begin
            b_q <= b_q + 1'b1;
            state_q <= LOAD;
          end else if (a_more) begin
            a_q <= a_q + 1'b1;
            b_q <= B_W'(B_MIN);
            state_q <= LOAD;
          end else state_q <= FIN;
        end
        FIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          found_q <= hit;
          a_out_q <= hit ? a_q : '0;
          b_out_q <= hit ? b_q : '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.found = found_q;
  assign bus.a_out = a_out_q;
  assign bus.b_out = b_out_q;
endmodule

// File: tb/tb_multiplier_factor_search.sv
// tb_multiplier_factor_search: cycle-level model check plus directed factoring vectors.
module tb_multiplier_factor_search;
  import multiplier_factor_pkg::*;
  localparam int A_W = 4;
  localparam int B_W = 3;
  localparam int P_W = A_W + B_W;
  localparam int A_MAX = (1 << A_W) - 1;
  localparam int B_MAX = (1 << B_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  multiplier_factor_search_if #(.A_W(A_W), .B_W(B_W)) bus ();
  multiplier_factor_search #(.A_W(A_W), .B_W(B_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic void search(input int n, output bit f, output int fa, output int fb, output int k);
    f = 1'b0;
    fa = 0;
    fb = 0;
    k = 0;
    for (int a = A_MIN; a <= A_MAX && !f; a++)
      for (int b = B_MIN; b <= B_MAX; b++) begin
        k++;
        if (a * b == n) begin
          f = 1'b1;
          fa = a;
          fb = b;
          break;
        end
`ifdef FACTOR_SEARCH_PRUNE_EN
        if (a * b > n) break;
`endif
      end
  endfunction
  bit m_armed = 1'b0;
  bit m_idle = 1'b1;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_found = 1'b0;
  int m_a = 0;
  int m_b = 0;
  int m_rem = 0;
  bit p_f;
  int p_a, p_b, p_k;
  always @(posedge clk) begin
    if (rst) begin
      m_armed = 1'b1;
      m_idle = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_found = 1'b0;
      m_a = 0;
      m_b = 0;
      m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_idle && bus.start) begin
        search(int'(bus.target), p_f, p_a, p_b, p_k);
        m_rem = p_k * (B_W + 2) + 1;
        m_idle = 1'b0;
        m_busy = 1'b1;
        m_found = 1'b0;
        m_a = 0;
        m_b = 0;
      end else if (!m_idle) begin
        m_rem--;
        if (m_rem == 0) begin
          m_idle = 1'b1;
          m_busy = 1'b0;
          m_done = 1'b1;
          m_found = p_f;
          m_a = p_a;
          m_b = p_b;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (m_armed) begin
      chk("model_busy", int'(bus.busy), int'(m_busy));
      chk("model_done", int'(bus.done), int'(m_done));
      chk("model_found", int'(bus.found), int'(m_found));
      chk("model_a_out", int'(bus.a_out), m_a);
      chk("model_b_out", int'(bus.b_out), m_b);
    end
  end
  task automatic run(input int n, input int inj_at, input int inj_n, output int lat, output int bc);
    lat = 0;
    bc = 0;
    bus.start = 1'b1;
    bus.target = P_W'(n);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    while (lat < 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = (lat == inj_at - 1);
      bus.target = P_W'((lat == inj_at - 1) ? inj_n : n);
      if (bus.busy) bc++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
  endtask
  task automatic res(input string tag, input int ef, input int ea, input int eb);
    chk({tag, "_found"}, int'(bus.found), ef);
    chk({tag, "_a_out"}, int'(bus.a_out), ea);
    chk({tag, "_b_out"}, int'(bus.b_out), eb);
  endtask
  initial begin
    bit f;
    int fa, fb, k, lat, bc, dones;
    bus.start = 1'b0;
    bus.target = '0;
    search(15, f, fa, fb, k);
    chk("pin15_k", k, 10);
    chk("pin15_a", fa, 3);
    chk("pin15_b", fb, 5);
    search(105, f, fa, fb, k);
    chk("pin105_k", k, 84);
    chk("pin105_f", int'(f), 1);
    search(4, f, fa, fb, k);
    chk("pin4_k", k, 1);
    chk("pin_sweep", sweep_count(A_W, B_W), 84);
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_found", int'(bus.found), 0);
    chk("rst_a_out", int'(bus.a_out), 0);
    chk("rst_b_out", int'(bus.b_out), 0);
    rst = 1'b0;
    @(negedge clk);
    run(4, 0, 0, lat, bc);
    chk("n4_lat", lat, 6);
    chk("n4_busy_cycles", bc, 5);
    res("n4", 1, 2, 2);
    run(15, 0, 0, lat, bc);
    chk("n15_lat", lat, 51);
    res("n15", 1, 3, 5);
    run(19, 10, 6, lat, bc);
`ifdef FACTOR_SEARCH_PRUNE_EN
    chk("n19_early", int'(lat < 421), 1);
`else
    chk("n19_lat", lat, 421);
`endif
    res("n19", 0, 0, 0);
    run(6, 0, 0, lat, bc);
    chk("n6_lat", lat, 11);
    res("n6", 1, 2, 3);
    run(105, 0, 0, lat, bc);
    chk("n105_lat", lat, 421);
    res("n105", 1, 15, 7);
    bus.start = 1'b1;
    bus.target = P_W'(105);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    res("abort", 0, 0, 0);
    rst = 1'b0;
    dones = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run(4, 0, 0, lat, bc);
    chk("post_rst_n4_lat", lat, 6);
    res("post_rst_n4", 1, 2, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multiplier_factor_search.md
# multiplier_factor_search

Sequential factor finder: the inverse of the multiplier-factorize benchmark circuits. Given a target N, it enumerates candidate pairs (a, b), both greater than 1, multiplies each pair with a shift-add datapath, and reports the first pair whose product equals N. If no pair matches, it reports that the target is unsatisfiable. It sits beside the benchmark set as a hardware golden reference for the SAT/UNSAT answer and the witness assignment.

## Interface
Parameters:
- A_W, 4: width of factor a
- B_W, 3: width of factor b
- P_W, A_W+B_W: width of the target and the product (derived; not overridable)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a search; accepted only in IDLE
- target  in  P_W  N; sampled in the accept cycle
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse at end of search
- found  out  1  valid with done, held until the next accept; 1 = SAT
- a_out  out  A_W  witness a; held; 0 when found=0
- b_out  out  B_W  witness b; held; 0 when found=0

## Operation
- States: IDLE, LOAD, MUL, CMP, FIN.
- IDLE:
  - On start=1, latch target.
  - Set a=2, b=2.
  - Clear found, a_out and b_out.
  - Go to LOAD.
  - start=0 in IDLE does nothing.
- LOAD (1 cycle):
  - Accumulator acc (P_W bits) = 0.
  - Load multiplicand = a (zero-extended to P_W) and multiplier shift register = b.
  - Bit counter = 0.
- MUL (exactly B_W cycles):
  - If the multiplier LSB is 1, acc += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, and the counter increments.
  - acc never overflows, because a·b < 2^P_W.
  - After B_W cycles, go to CMP.
- CMP (1 cycle):
  - If acc == target: found=1, a_out=a, b_out=b, go to FIN.
  - Else if b < 2^B_W−1: b++, go to LOAD.
  - Else if a < 2^A_W−1: a++, b=2, go to LOAD.
  - Else: found=0, go to FIN.
- FIN (1 cycle): assert done, go to IDLE.
- Order is a-major, b-minor, both ascending, so the reported witness is the pair with the lowest a, then the lowest b.
- start asserted while not in IDLE is ignored; it is not queued.
- Reset values:
  - state=IDLE
  - busy=0, done=0, found=0
  - a_out=0, b_out=0
  - all internal registers 0
- Reset mid-search aborts immediately. No done pulse is produced, and outputs return to their reset values.
- Targets below 4, and primes, yield found=0 after the full sweep.

## Timing
- Per candidate: B_W+2 cycles (LOAD + B_W MUL + CMP).
- Accept edge: start is sampled at edge t0; busy=1 from t0+1.
- done pulse: at edge t0 + K·(B_W+2) + 1, where K is the number of candidates examined (FIN is the cycle after the final CMP).
- busy and done: busy deasserts in the same cycle that done asserts.
- found, a_out and b_out become valid on that same edge.
- Full sweep without pruning: K = (2^A_W−2)·(2^B_W−2). For the defaults K=84, so done arrives at t0+421.
- Back-to-back: start may be asserted in the cycle after done; it is accepted because the block is then in IDLE.

## Configuration
- FACTOR_SEARCH_PRUNE_EN defined:
  - In CMP, if acc > target, skip the remaining b values for the current a.
  - Advance a with b=2, or go to FIN if a is at its maximum.
  - This is valid because the product is monotonic in b.
  - found, a_out and b_out are identical to the unpruned build; only K, and hence latency, shrinks.
- Macro undefined: the comparison is equality only and K follows the full order.

## Structure
- Shared package multiplier_factor_pkg holds:
  - the state enum (IDLE, LOAD, MUL, CMP, FIN)
  - the constants A_MIN=2 and B_MIN=2
  - a function computing the full-sweep candidate count for the benches
- One sub-module, shift_add_mul:
  - handles LOAD/MUL sequencing, with ports load, a, b, acc, valid
  - valid pulses after B_W cycles
- The top-level FSM owns enumeration, comparison and the result registers.

## Test plan
- Reset then N=4, start:
  - done at t0+6
  - found=1, a_out=2, b_out=2
  - busy high for exactly 5 cycles
- N=15:
  - K=10, done at t0+51
  - found=1, a_out=3, b_out=5
  - same result with PRUNE_EN
- N=19 (prime):
  - without the macro: done at t0+421, found=0, a_out=0, b_out=0
  - with PRUNE_EN: found=0 and done strictly earlier than t0+421
- N=105 (15·7, the maximal product):
  - found=1, a_out=15, b_out=7
  - it is the last candidate, so done at t0+421
- start pulsed with N=6 at t0+10 during an N=19 search:
  - the pulse is ignored and the N=19 result is unchanged
  - the next start after done with N=6 gives found=1, a_out=2, b_out=3
- rst asserted at t0+100 of an N=105 search:
  - next cycle: busy=0, done=0, found=0, outputs 0
  - no done pulse follows
  - a new N=4 search then completes at t0'+6
